// File: rtl/jtframe_rom_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : jtframe_rom_arb_if
// Description : Bundle joining ROM requesters and an SDRAM read port to the
//               arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface jtframe_rom_arb_if #(
    parameter int SLOTS = 4,
    parameter int AW    = 22
);
    logic [SLOTS-1:0]    slot_req;
    logic [SLOTS*AW-1:0] slot_addr;
    logic [31:0]         slot_dout;
    logic [SLOTS-1:0]    slot_ok;
    logic                sdram_req;
    logic [AW-1:0]       sdram_addr;
    logic                sdram_ack;
    logic                data_rdy;
    logic [31:0]         data_read;
    logic                downloading;
    logic                busy;

    // Arbiter side
    modport master (
        input  slot_req, slot_addr, sdram_ack, data_rdy, data_read, downloading,
        output slot_dout, slot_ok, sdram_req, sdram_addr, busy
    );

    // Requesters plus SDRAM controller side
    modport slave (
        output slot_req, slot_addr, sdram_ack, data_rdy, data_read, downloading,
        input  slot_dout, slot_ok, sdram_req, sdram_addr, busy
    );
endinterface
`default_nettype wire

// File: rtl/jtframe_rom_arb.sv
`default_nettype none
// ============================================================================
// Module      : jtframe_rom_arb
// Description : Round-robin arbiter sharing one SDRAM read port among SLOTS
//               ROM requesters, one transaction outstanding at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module jtframe_rom_arb #(
    parameter int SLOTS = 4,
    parameter int AW    = 22
) (
    input  logic               clk,
    input  logic               rst,
    jtframe_rom_arb_if.master  bus
);
    localparam int c_IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int c_SW = c_IW + 1;
    localparam logic [c_IW-1:0] c_LAST = c_IW'(SLOTS - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ACK  = 2'd1;
    localparam logic [1:0] c_DATA = 2'd2;

    logic [1:0]       r_st;
    logic [c_IW-1:0]  r_rr;
    logic [c_IW-1:0]  r_g;
    logic             r_sdram_req;
    logic [AW-1:0]    r_sdram_addr;
    logic [SLOTS-1:0] r_slot_ok;
    logic [31:0]      r_slot_dout;

    logic [AW-1:0]    w_addr [SLOTS];
    logic [c_SW-1:0]  w_sum;
    logic [c_IW-1:0]  w_gsel;
    logic             w_found;
    logic [c_IW-1:0]  w_next_rr;
    logic             w_hit;

    genvar i;
    generate
        for (i = 0; i < SLOTS; i++) begin : g_addr
            assign w_addr[i] = bus.slot_addr[i*AW +: AW];
        end
    endgenerate

    // Scan offsets from the far end so the nearest requester after r_rr wins
    always_comb begin
        w_found = 1'b0;
        w_gsel  = '0;
        w_sum   = '0;
        for (int k = SLOTS - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr} + c_SW'(k);
            if (w_sum >= c_SW'(SLOTS))
                w_sum = w_sum - c_SW'(SLOTS);
            if (bus.slot_req[w_sum[c_IW-1:0]]) begin
                w_found = 1'b1;
                w_gsel  = w_sum[c_IW-1:0];
            end
        end
    end

    assign w_next_rr = (r_g == c_LAST) ? '0 : r_g + 1'b1;
    // Data is only delivered if the requester still wants the same word
    assign w_hit     = bus.slot_req[r_g] && (w_addr[r_g] == r_sdram_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st         <= c_IDLE;
            r_rr         <= '0;
            r_g          <= '0;
            r_sdram_req  <= 1'b0;
            r_sdram_addr <= '0;
            r_slot_ok    <= '0;
            r_slot_dout  <= '0;
        end else begin
            r_slot_ok <= '0;
            case (r_st)
                c_IDLE: begin
                    if (!bus.downloading && r_slot_ok == '0 && w_found) begin
                        r_g          <= w_gsel;
                        r_sdram_addr <= w_addr[w_gsel];
                        r_sdram_req  <= 1'b1;
                        r_st         <= c_ACK;
                    end
                end
                c_ACK: begin
                    if (bus.sdram_ack) begin
                        r_sdram_req <= 1'b0;
                        r_st        <= c_DATA;
                    end
                end
                c_DATA: begin
                    if (bus.data_rdy) begin
                        r_slot_dout <= bus.data_read;
                        r_rr        <= w_next_rr;
                        if (w_hit)
                            r_slot_ok[r_g] <= 1'b1;
                        r_st        <= c_IDLE;
                    end
                end
                default: r_st <= c_IDLE;
            endcase
        end
    end

    assign bus.slot_ok    = r_slot_ok;
    assign bus.slot_dout  = r_slot_dout;
    assign bus.sdram_req  = r_sdram_req;
    assign bus.sdram_addr = r_sdram_addr;
    assign bus.busy       = (r_st != c_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_jtframe_rom_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtframe_rom_arb
// Description : Directed scenarios followed by random traffic checked against
//               a transaction-level model of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtframe_rom_arb;
    localparam int SLOTS = 4;
    localparam int AW    = 22;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    jtframe_rom_arb_if #(.SLOTS(SLOTS), .AW(AW)) bus ();

    jtframe_rom_arb #(.SLOTS(SLOTS), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int total = 0;
    int bad   = 0;
    logic [AW-1:0] addr [SLOTS];

    // Model of the port: 0 waiting to grant, 1 awaiting ack, 2 awaiting data
    int            ph;
    int            m_rr;
    int            m_g;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_dout;
    logic [3:0]    exp_ok;
    logic          okprev;
    logic [3:0]    e;
    int            w;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_addr;
        for (int i = 0; i < SLOTS; i++)
            bus.slot_addr[i*AW +: AW] = addr[i];
    endtask

    task automatic do_reset;
        rst = 1'b1;
        bus.slot_req    = '0;
        bus.sdram_ack   = 1'b0;
        bus.data_rdy    = 1'b0;
        bus.downloading = 1'b0;
        #1;
        chk("rst_req",  bus.sdram_req,  0);
        chk("rst_addr", bus.sdram_addr, 0);
        chk("rst_ok",   bus.slot_ok,    0);
        chk("rst_dout", bus.slot_dout,  0);
        chk("rst_busy", bus.busy,       0);
        tick;
        tick;
        rst = 1'b0;
    endtask

    initial begin
        bus.slot_addr = '0;
        bus.data_read = '0;
        for (int i = 0; i < SLOTS; i++) addr[i] = '0;
        do_reset;

        // Single request from slot 2
        addr[2] = 22'h00123; drive_addr;
        bus.slot_req = 4'b0100;
        tick;
        chk("single_req",  bus.sdram_req,  1);
        chk("single_addr", bus.sdram_addr, 22'h00123);
        chk("single_busy", bus.busy,       1);
        bus.sdram_ack = 1'b1;
        tick;
        bus.sdram_ack = 1'b0;
        chk("single_req_drop", bus.sdram_req, 0);
        chk("single_ok_early", bus.slot_ok,   0);
        bus.data_rdy = 1'b1; bus.data_read = 32'hDEADBEEF;
        tick;
        chk("single_ok",   bus.slot_ok,   4'b0100);
        chk("single_dout", bus.slot_dout, 32'hDEADBEEF);
        bus.data_rdy = 1'b0; bus.slot_req = '0; bus.data_read = 32'h0BAD0BAD;
        tick;
        chk("single_ok_pulse", bus.slot_ok,   0);
        chk("single_hold",     bus.slot_dout, 32'hDEADBEEF);
        chk("single_idle",     bus.busy,      0);

        // Contention: every slot requesting, controller answering at once
        do_reset;
        for (int i = 0; i < SLOTS; i++) addr[i] = {i[1:0], 20'h12340};
        drive_addr;
        bus.slot_req = 4'hF; bus.sdram_ack = 1'b1; bus.data_rdy = 1'b1;
        for (int n = 0; n < 5; n++) begin
            e = 4'b0001 << (n % SLOTS);
            bus.data_read = 32'hC0DE0000 + n;
            w = 0;
            do begin tick; w++; end while (bus.slot_ok == '0 && w < 8);
            chk("cont_ok",   bus.slot_ok,   e);
            chk("cont_dout", bus.slot_dout, 32'hC0DE0000 + n);
        end
        bus.slot_req = '0; bus.sdram_ack = 1'b0; bus.data_rdy = 1'b0;
        tick;

        // Slot 1 changes address while its data is in flight
        do_reset;
        addr[1] = 22'h0A5A5; drive_addr;
        bus.slot_req = 4'b0010;
        tick;
        chk("chg_addr_a", bus.sdram_addr, 22'h0A5A5);
        bus.sdram_ack = 1'b1;
        tick;
        bus.sdram_ack = 1'b0;
        addr[1] = 22'h15A5A; drive_addr;
        bus.data_rdy = 1'b1; bus.data_read = 32'h11111111;
        tick;
        chk("chg_no_ok", bus.slot_ok, 0);
        bus.data_rdy = 1'b0;
        tick;
        chk("chg_regrant", bus.sdram_req,  1);
        chk("chg_addr_b",  bus.sdram_addr, 22'h15A5A);
        bus.sdram_ack = 1'b1;
        tick;
        bus.sdram_ack = 1'b0; bus.data_rdy = 1'b1; bus.data_read = 32'h22222222;
        tick;
        chk("chg_ok",   bus.slot_ok,   4'b0010);
        chk("chg_dout", bus.slot_dout, 32'h22222222);
        bus.data_rdy = 1'b0; bus.slot_req = '0;
        tick;

        // Download gate, then download rising mid-transaction
        do_reset;
        addr[0] = 22'h00777; drive_addr;
        bus.downloading = 1'b1; bus.slot_req = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("dl_req",  bus.sdram_req, 0);
            chk("dl_busy", bus.busy,      0);
        end
        bus.downloading = 1'b0;
        tick;
        chk("dl_grant", bus.sdram_req,  1);
        chk("dl_addr",  bus.sdram_addr, 22'h00777);
        bus.downloading = 1'b1; bus.sdram_ack = 1'b1;
        tick;
        bus.sdram_ack = 1'b0; bus.data_rdy = 1'b1; bus.data_read = 32'h33333333;
        tick;
        chk("dl_mid_ok", bus.slot_ok, 4'b0001);
        bus.data_rdy = 1'b0; bus.slot_req = '0; bus.downloading = 1'b0;
        tick;

        // Slow controller with spurious data_rdy during the ack wait
        do_reset;
        addr[3] = 22'h3F00F; drive_addr;
        bus.slot_req = 4'b1000;
        tick;
        for (int i = 0; i < 5; i++) begin
            bus.data_rdy = i[0]; bus.data_read = 32'h99999999;
            tick;
            chk("slow_req",  bus.sdram_req,  1);
            chk("slow_addr", bus.sdram_addr, 22'h3F00F);
            chk("slow_ok",   bus.slot_ok,    0);
        end
        bus.data_rdy = 1'b0; bus.sdram_ack = 1'b1;
        tick;
        bus.sdram_ack = 1'b0;
        chk("slow_req_drop", bus.sdram_req, 0);
        for (int i = 0; i < 6; i++) begin
            tick;
            chk("slow_wait_busy", bus.busy,    1);
            chk("slow_wait_ok",   bus.slot_ok, 0);
        end
        bus.data_rdy = 1'b1; bus.data_read = 32'h44444444;
        tick;
        chk("slow_done_ok",   bus.slot_ok,   4'b1000);
        chk("slow_done_dout", bus.slot_dout, 32'h44444444);
        bus.data_rdy = 1'b0; bus.slot_req = '0;
        tick;

        // Reset while waiting for data
        do_reset;
        addr[2] = 22'h2BEEF; drive_addr;
        bus.slot_req = 4'b0100;
        tick;
        bus.sdram_ack = 1'b1;
        tick;
        bus.sdram_ack = 1'b0;
        tick;
        rst = 1'b1; bus.slot_req = '0;
        #1;
        chk("rdata_req",  bus.sdram_req,  0);
        chk("rdata_addr", bus.sdram_addr, 0);
        chk("rdata_busy", bus.busy,       0);
        tick;
        rst = 1'b0;
        bus.data_rdy = 1'b1; bus.data_read = 32'h55555555;
        tick;
        chk("rdata_no_ok", bus.slot_ok,   0);
        chk("rdata_dout",  bus.slot_dout, 0);
        bus.data_rdy = 1'b0;
        for (int i = 0; i < SLOTS; i++) addr[i] = {i[1:0], 20'h0F0F0};
        drive_addr;
        bus.slot_req = 4'hF;
        tick;
        chk("rdata_first", bus.sdram_addr, {2'd0, 20'h0F0F0});
        bus.sdram_ack = 1'b1;
        tick;
        bus.sdram_ack = 1'b0; bus.data_rdy = 1'b1;
        tick;
        chk("rdata_first_ok", bus.slot_ok, 4'b0001);
        bus.data_rdy = 1'b0; bus.slot_req = '0;
        tick;

        // Random traffic against the model
        do_reset;
        ph = 0; m_rr = 0; m_g = 0; m_addr = '0; m_dout = '0; exp_ok = '0; okprev = 1'b0;
        for (int c = 0; c < 600; c++) begin
            for (int s = 0; s < SLOTS; s++) begin
                if (exp_ok[s])
                    bus.slot_req[s] = 1'b0;
                else if (!bus.slot_req[s]) begin
                    if ($urandom_range(2) == 0) begin
                        bus.slot_req[s] = 1'b1;
                        addr[s] = {s[1:0], 20'($urandom)};
                    end
                end else if ($urandom_range(15) == 0)
                    addr[s] = {s[1:0], 20'($urandom)};
            end
            drive_addr;
            bus.downloading = ($urandom_range(7) == 0);
            bus.sdram_ack   = ($urandom_range(2) == 0);
            bus.data_rdy    = ($urandom_range(2) == 0);
            bus.data_read   = $urandom;

            exp_ok = '0;
            if (ph == 0) begin
                if (!bus.downloading && !okprev && bus.slot_req != '0) begin
                    for (int k = SLOTS - 1; k >= 0; k--)
                        if (bus.slot_req[(m_rr + k) % SLOTS]) m_g = (m_rr + k) % SLOTS;
                    m_addr = addr[m_g];
                    ph = 1;
                end
            end else if (ph == 1) begin
                if (bus.sdram_ack) ph = 2;
            end else if (bus.data_rdy) begin
                m_dout = bus.data_read;
                m_rr   = (m_g + 1) % SLOTS;
                if (bus.slot_req[m_g] && addr[m_g] == m_addr) exp_ok[m_g] = 1'b1;
                ph = 0;
            end
            okprev = (exp_ok != '0);

            tick;
            chk("rnd_ok",   bus.slot_ok,   exp_ok);
            chk("rnd_req",  bus.sdram_req, ph == 1);
            chk("rnd_busy", bus.busy,      ph != 0);
            chk("rnd_dout", bus.slot_dout, m_dout);
            if (ph != 0) chk("rnd_addr", bus.sdram_addr, m_addr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/jtframe_rom_arb.md
JTFRAME_ROM_ARB -- requirements
Module: jtframe_rom_arb

Interface
REQ-001 Parameter SLOTS, default 4, number of ROM requesters sharing the SDRAM read port (2..8).
REQ-002 Parameter AW, default 22, SDRAM word address width.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 slot_req  input  SLOTS  per-slot read request, level, held until slot_ok.
REQ-006 slot_addr  input  SLOTS*AW  per-slot address; slot i occupies bits [i*AW +: AW].
REQ-007 slot_dout  output  32  read data, valid while slot_ok has any bit high.
REQ-008 slot_ok  output  SLOTS  one-hot, one-cycle completion strobe.
REQ-009 sdram_req  output  1  request to SDRAM controller.
REQ-010 sdram_addr  output  AW  address to SDRAM controller.
REQ-011 sdram_ack  input  1  controller accepted request.
REQ-012 data_rdy  input  1  controller data_read valid, one-cycle pulse.
REQ-013 data_read  input  32  controller read data.
REQ-014 downloading  input  1  ROM download in progress; blocks new grants.
REQ-015 busy  output  1  high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, ACK, DATA; at most one SDRAM transaction outstanding.
REQ-017 IDLE: if downloading=0, no slot_ok bit high and any slot_req bit high, the block SHALL grant the first requesting slot scanning cyclically from pointer rr, latch grant index g and slot_addr[g], set sdram_req=1, sdram_addr=latched address, go to ACK.
REQ-018 ACK: sdram_req and sdram_addr SHALL stay constant until sdram_ack is sampled 1; on that edge sdram_req SHALL go 0 and the state SHALL go to DATA.
REQ-019 DATA: on the edge sampling data_rdy=1 the block SHALL register data_read into slot_dout, set rr=(g+1) mod SLOTS, and return to IDLE.
REQ-020 On that same edge slot_ok[g] SHALL go 1 for exactly one cycle only if slot_req[g]=1 and slot_addr[g] equals the latched address; otherwise data SHALL be discarded and slot_ok stays 0 (request still pending is re-arbitrated).
REQ-021 data_rdy in IDLE or ACK and sdram_ack in IDLE or DATA SHALL be ignored.
REQ-022 Latency: with sdram_ack high in the first ACK cycle and data_rdy in the first DATA cycle, slot_ok SHALL rise at the third rising edge counting the edge that samples slot_req as the first.
REQ-023 Fairness: a continuously requesting slot SHALL be granted within SLOTS grants.
REQ-024 downloading rising during ACK or DATA SHALL not abort the transaction; it completes per REQ-018..020.
REQ-025 slot_dout SHALL hold its value between completions.

Reset
REQ-026 While rst=1: state IDLE, rr=0, g=0, sdram_req=0, sdram_addr=0, slot_ok=0, slot_dout=0, busy=0, asynchronously.
REQ-027 rst asserted mid-transaction SHALL abandon it immediately; no slot_ok for it after release; first grant after release starts at slot 0.

Verification
REQ-028 Single: slot 2 requests addr 0x00123, ack in first ACK cycle, data_rdy next cycle with 0xDEADBEEF -> sdram_addr=0x00123, slot_ok=4'b0100 one cycle at third edge, slot_dout=0xDEADBEEF.
REQ-029 Contention: all 4 slots request continuously, ack/data immediate -> grant order 0,1,2,3,0; each slot_ok one-hot; never two bits high.
REQ-030 Address change: slot 1 changes addr during DATA -> no slot_ok for old data; new address issued next grant of slot 1.
REQ-031 Download gate: downloading=1 with slot 0 requesting -> sdram_req stays 0, busy=0; downloading=0 -> grant next cycle.
REQ-032 Slow controller: ack delayed 5 cycles, data_rdy delayed 7 -> sdram_req/sdram_addr stable over all ACK cycles, spurious data_rdy during ACK ignored.
REQ-033 Reset in DATA: rst pulse while waiting data_rdy, later data_rdy arrives -> no slot_ok, all outputs 0, next grant from slot 0.
